uart_rx_unit: RTL and testbench

UART receiver with receive FIFO. It is the counterpart of the transmit block uart_unit and shares its 50 MHz clock domain and 8N1 framing. It samples the asynchronous serial input line, recovers bytes LSB-first and buffers them in a DEPTH-entry FIFO. The CPU-side MMIO logic drains the FIFO with a first-word-fall-through read interface.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_unit_if.sv | 33 +++
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_unit.sv | 132 +++++++++++++
 tb/tb_uart_rx_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, RX deserializer states and baud divider helper.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_unit_if.sv
// Serial line plus CPU-side first-word-fall-through FIFO read port of the UART receiver.
interface uart_rx_unit_if;
    import uart_pkg::*;

    logic                 uart_input_line;
    logic                 uart_fifo_read_en;
    logic [DATA_BITS-1:0] uart_fifo_data;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 overrun;
    logic                 frame_error;

    modport slave (
        input  uart_input_line,
        input  uart_fifo_read_en,
        output uart_fifo_data,
        output fifo_empty,
        output fifo_full,
        output overrun,
        output frame_error
    );

    modport master (
        output uart_input_line,
        output uart_fifo_read_en,
        input  uart_fifo_data,
        input  fifo_empty,
        input  fifo_full,
        input  overrun,
        input  frame_error
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO, first-word-fall-through; a full FIFO still accepts a write when a read frees the slot.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_en,
    input  logic [DATA_BITS-1:0] write_data,
    input  logic                 read_en,
    output logic [DATA_BITS-1:0] read_data,
    output logic                 empty,
    output logic                 full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic                 do_read;
    logic                 do_write;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign do_read   = read_en && !empty;
    assign do_write  = write_en && (!full || do_read);
    // Gate the head with empty so the port reads zero after reset without clearing the array.
    assign read_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_read)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_write, do_read})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem_q[wr_ptr_q] <= write_data;
    end

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: line synchronizer, deserializer FSM and receive FIFO.
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a falling edge
//   RX_START | checking the middle of the start bit
//   RX_DATA  | sampling data bits LSB first
//   RX_STOP  | sampling the stop bit
//   RX_BREAK | framing error seen, waiting for the line to return high
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 32
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_unit_if.slave  bus
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W = $clog2(CPB);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CPB / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (CPB < 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STOP_BITS != 1) begin : g_bad_cfg
        $error("uart_rx_unit: unsupported CLK_FREQ/BAUD/DEPTH combination");
    end

    rx_state_e            state_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 push_q;
    logic                 frame_error_q;
    logic                 overrun_q;
    logic                 fifo_full_w;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.uart_input_line;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RX_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            push_q        <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            push_q        <= 1'b0;
            frame_error_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        state_q <= rx_s_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == IDX_LAST) state_q <= RX_STOP;
                        else                   idx_q   <= idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            push_q  <= 1'b1;
                            state_q <= RX_IDLE;
                        end else begin
                            frame_error_q <= 1'b1;
                            state_q       <= RX_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (rx_s_q) state_q <= RX_IDLE;
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    // A pop in the push cycle frees a slot, so only an unserviced full FIFO drops the byte.
    always_ff @(posedge clk) begin
        if (!rst) overrun_q <= 1'b0;
        else      overrun_q <= push_q && fifo_full_w && !bus.uart_fifo_read_en;
    end

    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .write_en   (push_q),
        .write_data (shift_q),
        .read_en    (bus.uart_fifo_read_en),
        .read_data  (bus.uart_fifo_data),
        .empty      (bus.fifo_empty),
        .full       (fifo_full_w)
    );

    assign bus.fifo_full   = fifo_full_w;
    assign bus.overrun     = overrun_q;
    assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Scoreboard bench for uart_rx_unit: frames are driven on the line, expected bytes queued, a monitor pops and compares.
module tb_uart_rx_unit;

    localparam int CPB   = 16;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_rx_unit_if bus();

    logic auto_rd = 1'b0;
    logic man_rd  = 1'b0;
    bit   auto_read = 1'b0;
    assign bus.uart_fifo_read_en = auto_rd | man_rd;

    int checks = 0;
    int errors = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;
    int ov0, fe0;
    logic [7:0] exp_q [$];

    uart_rx_unit #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts flag pulses and, when enabled, drains the FIFO against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            auto_rd = 1'b0;
            if (bus.overrun)     ov_cnt++;
            if (bus.frame_error) fe_cnt++;
            if (auto_read && !bus.fifo_empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", bus.uart_fifo_data);
                end else begin
                    chk("fifo_data", bus.uart_fifo_data, exp_q.pop_front());
                end
                auto_rd = 1'b1;
            end
        end
    end

    task automatic man_pop(input string name);
        chk({name, "_nonempty"}, bus.fifo_empty, 0);
        if (exp_q.size() > 0) chk(name, bus.uart_fifo_data, exp_q.pop_front());
        man_rd = 1'b1;
        @(negedge clk);
        man_rd = 1'b0;
    endtask

    // mode 1: check the empty->nonempty edge; mode 2: pop exactly on the push cycle.
    // Push lands at the posedge just before stop-bit negedge 12 (2 sync + start alignment).
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int mode);
        bus.uart_input_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_input_line = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.uart_input_line = stop_bit;
        for (int i = 0; i < CPB; i++) begin
            if (mode == 1 && i == 11) chk("empty_before_push", bus.fifo_empty, 1);
            if (mode == 1 && i == 12) begin
                chk("empty_after_push", bus.fifo_empty, 0);
                chk("head_after_push", bus.uart_fifo_data, exp_q[0]);
            end
            if (mode == 2 && i == 11) begin
                chk("full_before_pushpop", bus.fifo_full, 1);
                chk("head_on_pushpop", bus.uart_fifo_data, exp_q.pop_front());
                man_rd = 1'b1;
            end
            if (mode == 2 && i == 12) begin
                man_rd = 1'b0;
                chk("full_after_pushpop", bus.fifo_full, 1);
                chk("overrun_on_pushpop", bus.overrun, 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.fifo_empty) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        bus.uart_input_line = 1'b1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_empty", bus.fifo_empty, 1);
        chk("rst_full", bus.fifo_full, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_frame_error", bus.frame_error, 0);
        chk("rst_data", bus.uart_fifo_data, 8'h00);

        // single byte with exact push timing
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, 1);
        man_pop("pop_a5");
        chk("empty_after_read", bus.fifo_empty, 1);

        // back-to-back frames
        auto_read = 1'b1;
        ov0 = ov_cnt;
        fe0 = fe_cnt;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        wait_drain();
        chk("b2b_overrun", ov_cnt - ov0, 0);
        chk("b2b_frame_error", fe_cnt - fe0, 0);

        // short glitch
        bus.uart_input_line = 1'b0;
        repeat (4) @(negedge clk);
        bus.uart_input_line = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_empty", bus.fifo_empty, 1);
        chk("glitch_frame_error", fe_cnt - fe0, 0);

        // framing error followed by a held-low line
        send_byte(8'h3C, 1'b0, 0);
        repeat (24) @(negedge clk);
        chk("fe_pulse_once", fe_cnt - fe0, 1);
        bus.uart_input_line = 1'b1;
        repeat (200) @(negedge clk);
        chk("fe_after_break", fe_cnt - fe0, 1);
        chk("fe_empty", bus.fifo_empty, 1);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, 0);
        wait_drain();

        // overrun on the 33rd byte
        auto_read = 1'b0;
        ov0 = ov_cnt;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1, 0);
            if (i == DEPTH - 2) chk("not_full_at_31", bus.fifo_full, 0);
            if (i == DEPTH - 1) chk("full_at_32", bus.fifo_full, 1);
        end
        repeat (10) @(negedge clk);
        chk("overrun_once", ov_cnt - ov0, 1);
        chk("full_after_overrun", bus.fifo_full, 1);
        auto_read = 1'b1;
        wait_drain();
        chk("overrun_total", ov_cnt - ov0, 1);

        // reset in the middle of bit 3 of 8'h81
        bus.uart_input_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.uart_input_line = (i == 0);
            repeat (CPB) @(negedge clk);
        end
        bus.uart_input_line = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        bus.uart_input_line = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        chk("midreset_empty", bus.fifo_empty, 1);

        // full FIFO with a pop on the push cycle
        auto_read = 1'b0;
        ov0 = ov_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'(8'h40 + i));
            send_byte(8'(8'h40 + i), 1'b1, 0);
        end
        chk("full_before_77", bus.fifo_full, 1);
        exp_q.push_back(8'h77);
        send_byte(8'h77, 1'b1, 2);
        bus.uart_input_line = 1'b1;
        repeat (10) @(negedge clk);
        chk("pushpop_no_overrun", ov_cnt - ov0, 0);
        chk("pushpop_still_full", bus.fifo_full, 1);
        auto_read = 1'b1;
        wait_drain();
        chk("final_empty", bus.fifo_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
